ppu_vram_port: RTL and testbench

Buffered CPU-to-VRAM access engine for the PPU data port. It is the parametrised successor of the PPU's inline PPUADDR/PPUDATA logic. It decouples CPU register strobes from the video bus through an ordered command FIFO and a req/ack memory handshake that tolerates wait states, and it keeps the delayed-read buffer semantics. It sits between the PPU register decoder and the VRAM/cartridge video bus arbiter.

---
 rtl/ppu_vram_port_if.sv | 22 ++
 rtl/ppu_vram_port.sv | 156 +++++++++++++++
 tb/tb_ppu_vram_port.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_vram_port_if.sv
// Video-bus side of the PPU data port: a req/ack access channel with wait-state support.
interface ppu_vram_port_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/ppu_vram_port.sv
// Buffered CPU-to-VRAM access engine: PPUADDR/PPUDATA latch, ordered command FIFO, req/ack engine.
// Optional feature: define PPU_VRAM_PORT_OVERFLOW_EN for a sticky dropped-command flag.
module ppu_vram_port #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int INC_SMALL  = 1,
  parameter int INC_LARGE  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_addr,
  input  logic              i_wr_data,
  input  logic              i_rd_data,
  input  logic              i_clr_latch,
  input  logic              i_inc_large,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_rd_buffer,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_w,
  output logic              o_busy,
  output logic              o_full,
  output logic              o_overflow,
  ppu_vram_port_if.master   mem
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] t, v, inc;
  logic              w;
  logic [PW:0]       wr_ptr, rd_ptr;
  logic              fifo_we   [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic              empty, full, push, pop, data_stb;
  logic              do_rd, do_wrd, do_wra;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              req;

  // Fixed strobe priority: clr_latch > rd_data > wr_data > wr_addr.
  assign do_rd    = !i_clr_latch && i_rd_data;
  assign do_wrd   = !i_clr_latch && !i_rd_data && i_wr_data;
  assign do_wra   = !i_clr_latch && !i_rd_data && !i_wr_data && i_wr_addr;
  assign data_stb = do_rd || do_wrd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  // Fullness is judged on registered pointers, so a same-cycle pop never rescues a push.
  assign push  = data_stb && !full;
  assign inc   = i_inc_large ? ADDR_W'(INC_LARGE) : ADDR_W'(INC_SMALL);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      t <= '0;
      v <= '0;
      w <= 1'b0;
    end else if (i_clr_latch) begin
      w <= 1'b0;
    end else if (push) begin
      v <= v + inc;
    end else if (do_wra) begin
      if (!w) begin
        t <= {i_data[ADDR_W-9:0], t[7:0]};
        w <= 1'b1;
      end else begin
        t <= {t[ADDR_W-1:8], i_data[7:0]};
        v <= {t[ADDR_W-1:8], i_data[7:0]};
        w <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_we[wr_ptr[PW-1:0]]   <= do_wrd;
      fifo_addr[wr_ptr[PW-1:0]] <= v;
      fifo_data[wr_ptr[PW-1:0]] <= i_data;
    end
  end

  // Engine: pop into the request registers, hold them until ack.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          if (!empty) pop = 1'b1;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (pop) begin
      cur_we    <= fifo_we[rd_ptr[PW-1:0]];
      cur_addr  <= fifo_addr[rd_ptr[PW-1:0]];
      cur_wdata <= fifo_data[rd_ptr[PW-1:0]];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)                         o_rd_buffer <= '0;
    else if (req && mem.mem_ack && !cur_we) o_rd_buffer <= mem.mem_rdata;
  end

`ifdef PPU_VRAM_PORT_OVERFLOW_EN
  logic overflow;
  always_ff @(posedge i_clk) begin
    if (i_reset)               overflow <= 1'b0;
    else if (data_stb && full) overflow <= 1'b1;
  end
  assign o_overflow = overflow;
`else
  assign o_overflow = 1'b0;
`endif

  // Request-side data registers are unreset, so outputs are gated by req.
  assign req           = (state == REQ);
  assign mem.mem_req   = req;
  assign mem.mem_we    = req && cur_we;
  assign mem.mem_addr  = req ? cur_addr : '0;
  assign mem.mem_wdata = (req && cur_we) ? cur_wdata : '0;

  assign o_addr = v;
  assign o_w    = w;
  assign o_busy = !empty || req;
  assign o_full = full;
endmodule

// File: tb/tb_ppu_vram_port.sv
// Directed bench for ppu_vram_port: address latch, write stream, delayed read, wait states, wrap/reset.
module tb_ppu_vram_port;
  localparam int AW = 14;
  localparam int DW = 8;
`ifdef PPU_VRAM_PORT_OVERFLOW_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wr_addr, wr_data, rd_data, clr_latch, inc_large;
  logic [DW-1:0] data;
  logic [DW-1:0] rd_buffer;
  logic [AW-1:0] addr;
  logic          w, busy, full, overflow;
  logic          ack_en;

  ppu_vram_port_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  ppu_vram_port #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .INC_SMALL(1), .INC_LARGE(32)) dut (
    .i_clk(clk), .i_reset(rst), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_data(rd_data), .i_clr_latch(clr_latch), .i_inc_large(inc_large),
    .i_data(data), .o_rd_buffer(rd_buffer), .o_addr(addr), .o_w(w),
    .o_busy(busy), .o_full(full), .o_overflow(overflow), .mem(bus)
  );

  logic [DW-1:0] vram [0:(1<<AW)-1];
  assign bus.mem_ack   = ack_en && bus.mem_req;
  assign bus.mem_rdata = vram[bus.mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int log_addr[$];
  int log_data[$];
  int log_cyc[$];
  int req_seen = 0;

  always @(negedge clk) begin
    if (bus.mem_req) req_seen++;
    if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
      log_addr.push_back(int'(bus.mem_addr));
      log_data.push_back(int'(bus.mem_wdata));
      log_cyc.push_back(cyc);
      vram[bus.mem_addr] = bus.mem_wdata;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_wra(input logic [7:0] d);
    wr_addr = 1'b1;
    data    = d;
    tick();
    wr_addr = 1'b0;
  endtask

  task automatic set_addr(input logic [15:0] a);
    clr_latch = 1'b1;
    tick();
    clr_latch = 1'b0;
    strobe_wra(a[15:8]);
    strobe_wra(a[7:0]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    int s0;
    logic [7:0] exp_d [3];
    for (int i = 0; i < (1 << AW); i++) vram[i] = '0;
    rst = 1'b1; wr_addr = 0; wr_data = 0; rd_data = 0; clr_latch = 0; inc_large = 0;
    data = '0; ack_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_addr", addr, 0);
    chk("rst_w", w, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_rdbuf", rd_buffer, 0);
    chk("rst_ovf", overflow, 0);

    // Address latch
    strobe_wra(8'h21);
    chk("latch_hi_w", w, 1);
    chk("latch_hi_addr", addr, 0);
    strobe_wra(8'h08);
    chk("latch_addr", addr, 14'h2108);
    chk("latch_w", w, 0);
    clr_latch = 1'b1; tick(); clr_latch = 1'b0;
    chk("clr_w", w, 0);
    strobe_wra(8'h3F);
    chk("relatch_w", w, 1);
    chk("relatch_addr", addr, 14'h2108);

    // Write stream with ack tied high, large increment
    ack_en = 1'b1;
    inc_large = 1'b1;
    set_addr(16'h2000);
    chk("ws_start", addr, 14'h2000);
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    exp_d[0] = 8'hAA; exp_d[1] = 8'hBB; exp_d[2] = 8'hCC;
    wr_data = 1'b1;
    data = 8'hAA; s0 = cyc; tick();
    data = 8'hBB; tick();
    data = 8'hCC; tick();
    wr_data = 1'b0;
    wait_idle("ws_idle");
    chk("ws_count", log_addr.size(), 3);
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      chk("ws_addr", log_addr[i], 32'h2000 + 32'h20 * i);
      chk("ws_data", log_data[i], exp_d[i]);
      chk("ws_cyc", log_cyc[i], s0 + 2 + i);
    end
    chk("ws_v", addr, 14'h2060);

    // Delayed read
    vram[14'h0100] = 8'h55;
    vram[14'h0101] = 8'h66;
    inc_large = 1'b0;
    set_addr(16'h0100);
    rd_data = 1'b1;
    chk("rd1_sample", rd_buffer, 0);
    tick();
    rd_data = 1'b0;
    wait_idle("rd1_idle");
    rd_data = 1'b1;
    chk("rd2_sample", rd_buffer, 8'h55);
    tick();
    rd_data = 1'b0;
    chk("rd_v", addr, 14'h0102);
    wait_idle("rd2_idle");
    chk("rd2_result", rd_buffer, 8'h66);

    // Wait states: overflow the FIFO while ack is withheld
    ack_en = 1'b0;
    set_addr(16'h0200);
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    wr_data = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data = 8'(8'h11 + i);
      tick();
    end
    wr_data = 1'b0;
    chk("ws_full", full, 1);
    chk("ws_ovf", overflow, OVF_EXP);
    chk("ws_v5", addr, 14'h0205);
    tick(); tick();
    chk("hold_req", bus.mem_req, 1);
    chk("hold_we", bus.mem_we, 1);
    chk("hold_addr", bus.mem_addr, 14'h0200);
    chk("hold_wdata", bus.mem_wdata, 8'h11);
    ack_en = 1'b1;
    wait_idle("drain_idle");
    chk("drain_count", log_addr.size(), 5);
    for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
      chk("drain_addr", log_addr[i], 32'h0200 + i);
      chk("drain_data", log_data[i], 32'h11 + i);
    end
    chk("drain_full", full, 0);
    chk("drain_ovf", overflow, OVF_EXP);

    // Wrap and reset mid-access
    ack_en = 1'b0;
    set_addr(16'h3FFF);
    wr_data = 1'b1; data = 8'h77; tick();
    chk("wrap_v", addr, 14'h0000);
    data = 8'h78; tick();
    wr_data = 1'b0;
    chk("wrap_v1", addr, 14'h0001);
    chk("wrap_req", bus.mem_req, 1);
    chk("wrap_maddr", bus.mem_addr, 14'h3FFF);
    chk("pre_rst_rdbuf", rd_buffer, 8'h66);
    rst = 1'b1;
    tick();
    chk("mrst_req", bus.mem_req, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_rdbuf", rd_buffer, 0);
    chk("mrst_addr", addr, 0);
    chk("mrst_ovf", overflow, 0);
    rst = 1'b0;
    ack_en = 1'b1;
    req_seen = 0;
    repeat (5) tick();
    chk("post_rst_reqs", req_seen, 0);
    chk("post_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
